// File: rtl/i2s_sdma_pkg.sv
// Shared types and constants for the I2S RX -> SDMA request controller.
// Holds the FSM state encoding, the request-kind tag, the registered
// output bundle and the default configuration values.
package i2s_sdma_pkg;

  // Default configuration values for the controller parameters.
  localparam int FIFO_AW_DEF     = 9;
  localparam int TIMEOUT_CYC_DEF = 4096;

  // Width of the completed-transfer counter.
  localparam int XFER_CNT_W = 16;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Which SDMA request line is raised while in ST_REQ.
  typedef enum logic {
    REQ_BURST  = 1'b0,
    REQ_SINGLE = 1'b1
  } req_kind_e;

  // Registered control outputs, all derived from the state being entered.
  typedef struct packed {
    logic req;
    logic sreq;
    logic intr;
    logic busy;
  } ctrl_out_t;

  // Output decode for a given state/request kind. Because only ST_REQ can
  // raise a request, and the kind selects exactly one line, burst and
  // single requests can never be high together.
  function automatic ctrl_out_t decode_outputs(input state_e st, input req_kind_e kind);
    ctrl_out_t o;
    o      = '0;
    o.req  = (st == ST_REQ) && (kind == REQ_BURST);
    o.sreq = (st == ST_REQ) && (kind == REQ_SINGLE);
    o.intr = (st == ST_DONE);
    o.busy = (st != ST_IDLE);
    return o;
  endfunction

endpackage

// File: rtl/i2s_sdma_ctrl_if.sv
// SDMA channel handshake between the request controller (master) and the
// SDMA channel (slave): burst/single request out, active/done back.
interface i2s_sdma_ctrl_if;

  logic SDMA_Req_o;     // burst request to the channel
  logic SDMA_Sreq_o;    // single request to the channel
  logic SDMA_Active_i;  // channel has accepted and is running
  logic SDMA_Done_i;    // one-cycle completion pulse

  // Controller side.
  modport master (
    output SDMA_Req_o,
    output SDMA_Sreq_o,
    input  SDMA_Active_i,
    input  SDMA_Done_i
  );

  // Channel side.
  modport slave (
    input  SDMA_Req_o,
    input  SDMA_Sreq_o,
    output SDMA_Active_i,
    output SDMA_Done_i
  );

endinterface

// File: rtl/sdma_wdog.sv
// Request/transfer watchdog for i2s_sdma_ctrl.
// Only present when I2S_SDMA_TIMEOUT_EN is defined; without the macro this
// file is empty and the controller carries no watchdog logic at all.
// Counts enabled cycles after a clear and pulses o_expired during the
// TIMEOUT_CYC-th enabled cycle, so the owner can leave on that edge.
`ifdef I2S_SDMA_TIMEOUT_EN
module sdma_wdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_cnt_en,
  output logic o_expired
);

  // Counter only has to reach TIMEOUT_CYC-1: the owner always leaves the
  // counted states on the expiry edge, so it never needs to hold the limit.
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] r_cnt;

  assign o_expired = i_cnt_en && (r_cnt == CW'(TIMEOUT_CYC - 1));

  // Cycle counter: clear has priority over counting.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values and simulation matches the hardware.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_cnt_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/i2s_sdma_ctrl.sv
// I2S RX FIFO -> SDMA request controller.
// Raises a burst request when the FIFO reaches the watermark, or a single
// request while flushing below it, follows the channel through the transfer,
// and pulses DMA_Intr_o / bumps Xfer_Cnt_o once per completed transfer.
// Optional watchdog: define I2S_SDMA_TIMEOUT_EN to abort REQ/XFER after
// TIMEOUT_CYC cycles and raise the sticky Err_Intr_o flag.
module i2s_sdma_ctrl
  import i2s_sdma_pkg::*;
#(
  parameter int FIFO_AW     = FIFO_AW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  WB_CLK,
  input  logic                  WB_RST_n,
  input  logic                  Enable_i,
  input  logic                  Flush_i,
  input  logic [FIFO_AW:0]      Watermark_i,
  input  logic [FIFO_AW:0]      Fifo_Level_i,
  i2s_sdma_ctrl_if.master       sdma,
  output logic                  DMA_Intr_o,
  output logic                  Err_Intr_o,
  input  logic                  Err_Clr_i,
  output logic [XFER_CNT_W-1:0] Xfer_Cnt_o,
  output logic                  Busy_o
);

  state_e                r_state;
  state_e                w_next_state;
  req_kind_e             r_kind;
  req_kind_e             w_next_kind;
  ctrl_out_t             r_out;
  logic                  r_cool;      // first IDLE cycle after DONE
  logic [XFER_CNT_W-1:0] r_cnt;
  logic                  w_burst_ok;
  logic                  w_single_ok;
  logic                  w_wd_expired;

  // Request conditions as seen in IDLE; burst wins when both hold.
  assign w_burst_ok  = (Watermark_i != '0) && (Fifo_Level_i >= Watermark_i);
  assign w_single_ok = Flush_i && (Fifo_Level_i != '0);

  // Next-state and request-kind selection.
  // NOTE: every signal driven here gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_kind  = r_kind;
    case (r_state)
      ST_IDLE: begin
        // The cool-down cycle ignores a FIFO level that may still reflect
        // the data the finished transfer just drained.
        if (Enable_i && !r_cool) begin
          if (w_burst_ok) begin
            w_next_state = ST_REQ;
            w_next_kind  = REQ_BURST;
          end else if (w_single_ok) begin
            w_next_state = ST_REQ;
            w_next_kind  = REQ_SINGLE;
          end
        end
      end
      ST_REQ: begin
        // Once the channel has accepted, the transfer is committed even if
        // Enable_i drops in the same cycle.
        if (w_wd_expired) begin
          w_next_state = ST_IDLE;
        end else if (sdma.SDMA_Active_i) begin
          w_next_state = sdma.SDMA_Done_i ? ST_DONE : ST_XFER;
        end else if (!Enable_i) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_XFER: begin
        // Enable_i is deliberately not looked at: a running transfer finishes.
        if (w_wd_expired) begin
          w_next_state = ST_IDLE;
        end else if (sdma.SDMA_Done_i) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register plus registered outputs decoded from the state being
  // entered, so every output changes on the same edge as the state.
  always_ff @(posedge WB_CLK) begin
    if (!WB_RST_n) begin
      r_state <= ST_IDLE;
      r_kind  <= REQ_BURST;
      r_out   <= '0;
      r_cool  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_kind  <= w_next_kind;
      r_out   <= decode_outputs(w_next_state, w_next_kind);
      r_cool  <= (r_state == ST_DONE);
      if (w_next_state == ST_DONE) begin
        r_cnt <= r_cnt + 1'b1;  // wraps 0xFFFF -> 0
      end
    end
  end

`ifdef I2S_SDMA_TIMEOUT_EN
  logic w_wd_clr;
  logic w_wd_cnt_en;
  logic r_err;

  // Watchdog runs in REQ and XFER and restarts on entry to either state,
  // so the request phase and the transfer phase each get a full budget.
  assign w_wd_cnt_en = (r_state == ST_REQ) || (r_state == ST_XFER);
  assign w_wd_clr    = (w_next_state != r_state) &&
                       ((w_next_state == ST_REQ) || (w_next_state == ST_XFER));

  sdma_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .i_clk     (WB_CLK),
    .i_rst_n   (WB_RST_n),
    .i_clr     (w_wd_clr),
    .i_cnt_en  (w_wd_cnt_en),
    .o_expired (w_wd_expired)
  );

  // Sticky error flag: a new timeout wins over a clear in the same cycle.
  always_ff @(posedge WB_CLK) begin
    if (!WB_RST_n) begin
      r_err <= 1'b0;
    end else if (w_wd_expired) begin
      r_err <= 1'b1;
    end else if (Err_Clr_i) begin
      r_err <= 1'b0;
    end
  end

  assign Err_Intr_o = r_err;
`else
  // No watchdog: the error flag is constant and the clear input is unused.
  logic w_unused_cfg;

  assign w_wd_expired = 1'b0;
  assign Err_Intr_o   = 1'b0;
  assign w_unused_cfg = Err_Clr_i ^ (TIMEOUT_CYC == 0);
`endif

  assign sdma.SDMA_Req_o  = r_out.req;
  assign sdma.SDMA_Sreq_o = r_out.sreq;
  assign DMA_Intr_o       = r_out.intr;
  assign Busy_o           = r_out.busy;
  assign Xfer_Cnt_o       = r_cnt;

endmodule

// File: doc/i2s_sdma_ctrl.md
I2S_SDMA_CTRL -- requirements
Module: i2s_sdma_ctrl

Interface
REQ-001 Parameter FIFO_AW, default 9, SHALL set the FIFO level width to FIFO_AW+1 bits (level range 0..512).
REQ-002 Parameter TIMEOUT_CYC, default 4096, SHALL set the watchdog limit in WB_CLK cycles.
REQ-003 WB_CLK  input  1  sole clock; all logic is rising-edge.
REQ-004 WB_RST_n  input  1  reset; synchronous, active-low.
REQ-005 Enable_i  input  1  arms the request engine.
REQ-006 Flush_i  input  1  level; when high, a single request is allowed below the watermark.
REQ-007 Watermark_i  input  FIFO_AW+1  burst threshold in words; 0 disables burst requests.
REQ-008 Fifo_Level_i  input  FIFO_AW+1  current RX FIFO occupancy.
REQ-009 SDMA_Req_o  output  1  burst request to the SDMA channel.
REQ-010 SDMA_Sreq_o  output  1  single request to the SDMA channel.
REQ-011 SDMA_Active_i  input  1  channel has accepted and is running.
REQ-012 SDMA_Done_i  input  1  one-cycle completion pulse.
REQ-013 DMA_Intr_o  output  1  one-cycle pulse per completed transfer.
REQ-014 Err_Intr_o  output  1  sticky watchdog error flag.
REQ-015 Err_Clr_i  input  1  clears Err_Intr_o.
REQ-016 Xfer_Cnt_o  output  16  completed-transfer count.
REQ-017 Busy_o  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ, XFER, DONE. All outputs are registered.
REQ-019 IDLE->REQ, burst: Enable_i=1, Watermark_i!=0 and Fifo_Level_i>=Watermark_i. SDMA_Req_o=1 from the next cycle.
REQ-020 IDLE->REQ, single: Enable_i=1, Flush_i=1, burst condition false and Fifo_Level_i!=0. SDMA_Sreq_o=1 from the next cycle.
REQ-021 Burst SHALL take priority over single when both conditions hold.
REQ-022 In REQ, the asserted request SHALL hold until SDMA_Active_i=1 is sampled, then drop on the next edge; the FSM moves to XFER.
REQ-023 SDMA_Req_o and SDMA_Sreq_o SHALL never be high in the same cycle.
REQ-024 In REQ, Enable_i=0 SHALL drop the request on the next edge and return the FSM to IDLE; no interrupt, no count.
REQ-025 In XFER, Enable_i=0 SHALL be ignored; the transfer runs to SDMA_Done_i.
REQ-026 XFER->DONE on SDMA_Done_i=1.
REQ-027 In REQ, SDMA_Active_i=1 and SDMA_Done_i=1 in the same cycle SHALL go directly to DONE.
REQ-028 DONE SHALL last exactly one cycle: DMA_Intr_o=1, Xfer_Cnt_o+1 (wraps 0xFFFF->0), then IDLE.
REQ-029 After DONE, IDLE SHALL not re-request for one cycle, so a stale FIFO level cannot trigger a request.
REQ-030 SDMA_Done_i outside XFER/REQ SHALL be ignored.
REQ-031 Err_Clr_i SHALL clear Err_Intr_o.
REQ-032 Err_Clr_i in the same cycle as a new error SHALL leave Err_Intr_o set.

Reset
REQ-033 When WB_RST_n=0 at a clock edge: state=IDLE, SDMA_Req_o=0, SDMA_Sreq_o=0, DMA_Intr_o=0, Err_Intr_o=0, Xfer_Cnt_o=0, Busy_o=0, watchdog=0.
REQ-034 Reset asserted mid-transfer SHALL abort immediately with no interrupt.

Configuration
REQ-035 Macro I2S_SDMA_TIMEOUT_EN defined: the watchdog counts cycles in REQ and XFER and clears on entry to either state. When it reaches TIMEOUT_CYC it sets Err_Intr_o, drops both requests, and returns the FSM to IDLE with no DMA_Intr_o.
REQ-036 Macro I2S_SDMA_TIMEOUT_EN undefined: no watchdog logic; Err_Intr_o is tied 0 and Err_Clr_i is ignored.

Structure
REQ-037 Package i2s_sdma_pkg SHALL hold the FSM state enum, the default FIFO_AW/TIMEOUT_CYC constants, and the Xfer_Cnt width constant.
REQ-038 The watchdog SHALL be the sub-module sdma_wdog (clear, count-enable, expired pulse), instantiated only under I2S_SDMA_TIMEOUT_EN.

Verification
REQ-039 Burst: Watermark=128, level 127->128, Active after 5 cycles, Done after 20 -> Req high 1 cycle after level=128, drops 1 cycle after Active; one DMA_Intr_o pulse; Xfer_Cnt=1.
REQ-040 Flush: Watermark=128, level=3, Flush=1 -> Sreq_o only, Req_o stays 0; completes with Xfer_Cnt+1.
REQ-041 Disable: Enable drops during REQ -> Req low next cycle, IDLE, no interrupt. Enable drops during XFER -> transfer completes normally.
REQ-042 Simultaneous/wrap: Active and Done in the same REQ cycle -> DONE next cycle. Start from Xfer_Cnt=0xFFFF -> wraps to 0.
REQ-043 Timeout (macro on, TIMEOUT_CYC=16): no Active -> Err_Intr_o set at cycle 16 of REQ, Req low, IDLE. Err_Clr_i clears it. With the macro off, Err_Intr_o stays 0 indefinitely.
REQ-044 Reset: WB_RST_n=0 during XFER -> all outputs 0 at the next edge, no DMA_Intr_o.
